// File: rtl/histogram_sequencer_pkg.sv
// Shared constants and FSM encoding for the projection-histogram sequencer.
package histogram_sequencer_pkg;

    localparam int IMWIDTH  = 240;
    localparam int IMHEIGHT = 180;
    localparam int BIN_W    = 8;
    localparam int IDX_W    = 8;

    typedef enum logic [2:0] {
        INIT_CLEAR = 3'd0,
        IDLE       = 3'd1,
        ARM        = 3'd2,
        COMPUTE    = 3'd3,
        READ_REQ   = 3'd4,
        READ       = 3'd5,
        CLEAR      = 3'd6,
        RESULT     = 3'd7
    } seq_state_e;

endpackage

// File: rtl/histogram_sequencer_peak_tracker.sv
// Valid-qualified argmax over one streamed histogram axis; the lowest index wins ties.
module histogram_sequencer_peak_tracker #(
    parameter int LIMIT = histogram_sequencer_pkg::IMWIDTH,
    parameter int CNT_W = histogram_sequencer_pkg::BIN_W,
    parameter int IX_W  = histogram_sequencer_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             valid,
    input  logic [CNT_W-1:0] bin,
    output logic [IX_W-1:0]  peak_idx,
    output logic [CNT_W-1:0] peak_cnt
);
    localparam logic [IX_W-1:0] LAST = IX_W'(LIMIT - 1);

    logic [IX_W-1:0]  idx_q, idx_d;
    logic [IX_W-1:0]  peak_idx_q, peak_idx_d;
    logic [CNT_W-1:0] peak_cnt_q, peak_cnt_d;

    always_comb begin
        idx_d      = idx_q;
        peak_idx_d = peak_idx_q;
        peak_cnt_d = peak_cnt_q;
        if (clr) begin
            idx_d      = '0;
            peak_idx_d = '0;
            peak_cnt_d = '0;
        end else if (valid) begin
            if (bin > peak_cnt_q) begin
                peak_cnt_d = bin;
                peak_idx_d = idx_q;
            end
            // Extra beats beyond the axis length all land on the last index.
            if (idx_q != LAST) idx_d = idx_q + IX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= '0;
            peak_idx_q <= '0;
            peak_cnt_q <= '0;
        end else begin
            idx_q      <= idx_d;
            peak_idx_q <= peak_idx_d;
            peak_cnt_q <= peak_cnt_d;
        end
    end

    assign peak_idx = peak_idx_q;
    assign peak_cnt = peak_cnt_q;

endmodule

// File: rtl/histogram_sequencer.sv
// Drives the histogram engine through start/stop/read/clear per frame and
// publishes the per-axis peak bin over a valid/ready handshake.
module histogram_sequencer #(
    parameter int IMWIDTH  = histogram_sequencer_pkg::IMWIDTH,
    parameter int IMHEIGHT = histogram_sequencer_pkg::IMHEIGHT,
    parameter int BIN_W    = histogram_sequencer_pkg::BIN_W,
    parameter int IDX_W    = histogram_sequencer_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             frame_end,
    input  logic             hist_ready,
    input  logic             histogram_clear,
    input  logic [BIN_W-1:0] x_bin,
    input  logic             x_valid,
    input  logic [BIN_W-1:0] y_bin,
    input  logic             y_valid,
    output logic             start_histogram,
    output logic             stop_histogram,
    output logic             read_histogram,
    output logic             clear_histogram,
    output logic [IDX_W-1:0] peak_x,
    output logic [BIN_W-1:0] peak_x_count,
    output logic [IDX_W-1:0] peak_y,
    output logic [BIN_W-1:0] peak_y_count,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic             frame_dropped
);
    import histogram_sequencer_pkg::*;

    seq_state_e state_q, state_d;
    logic start_q, start_d, stop_q, stop_d, read_q, read_d, clear_q, clear_d;
    logic result_valid_q, result_valid_d, busy_q, busy_d, dropped_q, dropped_d;
    logic cmd_sent_q, cmd_sent_d, seen_busy_q, seen_busy_d;
    logic trk_clr;

    always_comb begin
        state_d        = state_q;
        start_d        = 1'b0;
        stop_d         = 1'b0;
        read_d         = 1'b0;
        clear_d        = 1'b0;
        result_valid_d = result_valid_q;
        cmd_sent_d     = cmd_sent_q;
        // Engine ready lags a command, so only a drop seen after the command counts.
        seen_busy_d    = seen_busy_q | ~hist_ready;
        trk_clr        = 1'b0;
        dropped_d      = frame_start && (state_q != IDLE);
        unique case (state_q)
            INIT_CLEAR, CLEAR: begin
                if (!cmd_sent_q) begin
                    if (hist_ready) begin
                        clear_d     = 1'b1;
                        cmd_sent_d  = 1'b1;
                        seen_busy_d = 1'b0;
                    end
                end else if (seen_busy_q && histogram_clear &&
                             (hist_ready || state_q == CLEAR)) begin
                    cmd_sent_d = 1'b0;
                    if (state_q == CLEAR) begin
                        state_d        = RESULT;
                        result_valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            IDLE:     if (frame_start) state_d = ARM;
            ARM: begin
                if (hist_ready) begin
                    start_d = 1'b1;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (frame_end) begin
                    stop_d      = 1'b1;
                    seen_busy_d = 1'b0;
                    state_d     = READ_REQ;
                end
            end
            READ_REQ: begin
                if (seen_busy_q && hist_ready) begin
                    read_d      = 1'b1;
                    trk_clr     = 1'b1;
                    seen_busy_d = 1'b0;
                    state_d     = READ;
                end
            end
            READ:     if (seen_busy_q && hist_ready) state_d = CLEAR;
            RESULT: begin
                if (result_valid_q && result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default:  state_d = INIT_CLEAR;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= INIT_CLEAR;
            start_q        <= 1'b0;
            stop_q         <= 1'b0;
            read_q         <= 1'b0;
            clear_q        <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            dropped_q      <= 1'b0;
            cmd_sent_q     <= 1'b0;
            seen_busy_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            stop_q         <= stop_d;
            read_q         <= read_d;
            clear_q        <= clear_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            dropped_q      <= dropped_d;
            cmd_sent_q     <= cmd_sent_d;
            seen_busy_q    <= seen_busy_d;
        end
    end

    histogram_sequencer_peak_tracker #(.LIMIT(IMWIDTH), .CNT_W(BIN_W), .IX_W(IDX_W)) u_peak_x (
        .clk(clk), .reset(reset), .clr(trk_clr), .valid(x_valid && state_q == READ),
        .bin(x_bin), .peak_idx(peak_x), .peak_cnt(peak_x_count)
    );

    histogram_sequencer_peak_tracker #(.LIMIT(IMHEIGHT), .CNT_W(BIN_W), .IX_W(IDX_W)) u_peak_y (
        .clk(clk), .reset(reset), .clr(trk_clr), .valid(y_valid && state_q == READ),
        .bin(y_bin), .peak_idx(peak_y), .peak_cnt(peak_y_count)
    );

    assign start_histogram = start_q;
    assign stop_histogram  = stop_q;
    assign read_histogram  = read_q;
    assign clear_histogram = clear_q;
    assign result_valid    = result_valid_q;
    assign busy            = busy_q;
    assign frame_dropped   = dropped_q;

endmodule

// File: tb/tb_histogram_sequencer.sv
// Directed bench: a behavioural engine model answers the command pulses and streams bins.
module tb_histogram_sequencer;
    localparam int IMW = 240;
    localparam int IMH = 180;

    logic       clk = 1'b0, reset = 1'b1;
    logic       frame_start = 1'b0, frame_end = 1'b0, result_ready = 1'b0;
    logic       hist_ready = 1'b1, histogram_clear = 1'b0;
    logic [7:0] x_bin = '0, y_bin = '0;
    logic       x_valid = 1'b0, y_valid = 1'b0;
    logic       start_histogram, stop_histogram, read_histogram, clear_histogram;
    logic [7:0] peak_x, peak_x_count, peak_y, peak_y_count;
    logic       result_valid, busy, frame_dropped;

    int checks = 0, errors = 0;
    logic [7:0] xq [256];
    logic [7:0] yq [256];
    int nx_beats = IMW, ny_beats = IMH;
    int n_start = 0, n_stop = 0, n_read = 0, n_clear = 0, n_drop = 0, n_wide = 0;
    logic [3:0] prev_cmd = '0;

    histogram_sequencer dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
        .hist_ready(hist_ready), .histogram_clear(histogram_clear),
        .x_bin(x_bin), .x_valid(x_valid), .y_bin(y_bin), .y_valid(y_valid),
        .start_histogram(start_histogram), .stop_histogram(stop_histogram),
        .read_histogram(read_histogram), .clear_histogram(clear_histogram),
        .peak_x(peak_x), .peak_x_count(peak_x_count), .peak_y(peak_y), .peak_y_count(peak_y_count),
        .result_valid(result_valid), .result_ready(result_ready), .busy(busy),
        .frame_dropped(frame_dropped)
    );

    always #5 clk = ~clk;

    // Engine model: ready drops 2 cycles after a command, clear takes 4 more, stop 3 more.
    typedef enum {E_IDLE, E_LAG, E_RUN, E_FIN, E_STREAM, E_CLRW} eng_e;
    eng_e es = E_IDLE;
    int   cmd = 0, cnt = 0, bx = 0;

    always @(negedge clk) begin
        if (reset) begin
            hist_ready = 1'b1; histogram_clear = 1'b0; x_valid = 1'b0; y_valid = 1'b0;
            es = E_IDLE;
        end else begin
            case (es)
                E_IDLE: begin
                    if (start_histogram)      begin cmd = 1; cnt = 2; es = E_LAG; end
                    else if (read_histogram)  begin cmd = 2; cnt = 2; es = E_LAG; end
                    else if (clear_histogram) begin cmd = 3; cnt = 2; es = E_LAG; histogram_clear = 1'b0; end
                end
                E_LAG: begin
                    cnt--;
                    if (cnt == 0) begin
                        hist_ready = 1'b0;
                        if (cmd == 1) es = E_RUN;
                        else if (cmd == 2) begin es = E_STREAM; bx = 0; end
                        else begin es = E_CLRW; cnt = 4; end
                    end
                end
                E_RUN:  if (stop_histogram) begin es = E_FIN; cnt = 3; end
                E_FIN: begin
                    cnt--;
                    if (cnt == 0) begin hist_ready = 1'b1; es = E_IDLE; end
                end
                E_STREAM: begin
                    x_valid = (bx < nx_beats);
                    y_valid = (bx < ny_beats);
                    x_bin   = x_valid ? xq[bx] : 8'd0;
                    y_bin   = y_valid ? yq[bx] : 8'd0;
                    if (bx >= nx_beats && bx >= ny_beats) begin hist_ready = 1'b1; es = E_IDLE; end
                    bx++;
                end
                E_CLRW: begin
                    cnt--;
                    if (cnt == 0) begin hist_ready = 1'b1; histogram_clear = 1'b1; es = E_IDLE; end
                end
                default: es = E_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (start_histogram) n_start++;
        if (stop_histogram)  n_stop++;
        if (read_histogram)  n_read++;
        if (clear_histogram) n_clear++;
        if (frame_dropped)   n_drop++;
        if (({start_histogram, stop_histogram, read_histogram, clear_histogram} & prev_cmd) != 4'b0) n_wide++;
        prev_cmd = {start_histogram, stop_histogram, read_histogram, clear_histogram};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic set_bins();
        for (int i = 0; i < 256; i++) begin xq[i] = 8'd0; yq[i] = 8'd0; end
        nx_beats = IMW; ny_beats = IMH;
    endtask

    task automatic wait_idle(output bit ok);
        int k = 0;
        while (busy !== 1'b0 && k < 3000) begin step(); k++; end
        ok = (busy === 1'b0);
    endtask

    task automatic wait_result(output bit ok);
        int k = 0;
        while (result_valid !== 1'b1 && k < 3000) begin step(); k++; end
        ok = (result_valid === 1'b1);
    endtask

    task automatic run_frame(input bit end_with_start, output bit ok);
        frame_start = 1'b1; frame_end = end_with_start; step();
        frame_start = 1'b0; frame_end = 1'b0;
        repeat (10) step();
        frame_end = 1'b1; step(); frame_end = 1'b0;
        wait_result(ok);
    endtask

    task automatic accept();
        result_ready = 1'b1; step(); result_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit ok; int c0, s0;
        reset = 1'b1; repeat (3) step();
        checks++;
        if ({start_histogram, stop_histogram, read_histogram, clear_histogram, result_valid, busy,
             frame_dropped, peak_x, peak_x_count, peak_y, peak_y_count} !== '0) begin
            errors++; $display("FAIL reset_outputs: some output nonzero, busy=%b clr=%b", busy, clear_histogram);
        end
        c0 = n_clear; s0 = n_start;
        reset = 1'b0; step(); step();
        checks++;
        if (n_clear - c0 !== 1) begin errors++; $display("FAIL init_clear_pulse: got %0d want 1", n_clear - c0); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL init_busy: got %b want 1", busy); end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL init_to_idle: busy=%b want 0", busy); end
        checks++;
        if (n_clear - c0 !== 1 || n_start !== s0) begin
            errors++; $display("FAIL init_cmds: clears=%0d starts=%0d want 1 0", n_clear - c0, n_start - s0);
        end
    endtask

    task automatic test_peak_basic();
        bit ok; int s0, p0, r0, c0;
        set_bins(); xq[17] = 8'd5; xq[200] = 8'd9;
        for (int i = 0; i < IMH; i++) yq[i] = 8'd3;
        s0 = n_start; p0 = n_stop; r0 = n_read; c0 = n_clear;
        run_frame(1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_result_valid: got %b want 1", result_valid); end
        checks++;
        if (peak_x !== 8'd200 || peak_x_count !== 8'd9) begin
            errors++; $display("FAIL basic_peak_x: got %0d/%0d want 200/9", peak_x, peak_x_count);
        end
        checks++;
        if (peak_y !== 8'd0 || peak_y_count !== 8'd3) begin
            errors++; $display("FAIL basic_peak_y: got %0d/%0d want 0/3", peak_y, peak_y_count);
        end
        checks++;
        if (n_start - s0 !== 1 || n_stop - p0 !== 1 || n_read - r0 !== 1 || n_clear - c0 !== 1) begin
            errors++; $display("FAIL basic_cmds: s/p/r/c=%0d/%0d/%0d/%0d want 1/1/1/1",
                               n_start - s0, n_stop - p0, n_read - r0, n_clear - c0);
        end
        accept();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_accept: valid=%b busy=%b want 0 0", result_valid, busy);
        end
    endtask

    task automatic test_tie();
        bit ok; int p0;
        set_bins(); xq[4] = 8'd7; xq[90] = 8'd7; yq[179] = 8'd1;
        p0 = n_stop;
        run_frame(1'b1, ok);
        checks++;
        if (!ok || peak_x !== 8'd4 || peak_x_count !== 8'd7) begin
            errors++; $display("FAIL tie_peak_x: got %0d/%0d want 4/7", peak_x, peak_x_count);
        end
        checks++;
        if (peak_y !== 8'd179 || peak_y_count !== 8'd1) begin
            errors++; $display("FAIL tie_peak_y_last: got %0d/%0d want 179/1", peak_y, peak_y_count);
        end
        checks++;
        if (n_stop - p0 !== 1) begin errors++; $display("FAIL tie_stop_count: got %0d want 1", n_stop - p0); end
        accept();
    endtask

    task automatic test_saturate_zero();
        bit ok;
        set_bins(); nx_beats = 244; xq[10] = 8'd100; xq[243] = 8'd200;
        run_frame(1'b0, ok);
        checks++;
        if (!ok || peak_x !== 8'd239 || peak_x_count !== 8'd200) begin
            errors++; $display("FAIL sat_peak_x: got %0d/%0d want 239/200", peak_x, peak_x_count);
        end
        checks++;
        if (peak_y !== 8'd0 || peak_y_count !== 8'd0) begin
            errors++; $display("FAIL zero_peak_y: got %0d/%0d want 0/0", peak_y, peak_y_count);
        end
        accept();
        set_bins();
    endtask

    task automatic test_drop();
        bit ok; int s0, d0;
        set_bins(); xq[50] = 8'd20; yq[60] = 8'd30;
        s0 = n_start; d0 = n_drop;
        frame_start = 1'b1; step(); frame_start = 1'b0;
        repeat (5) step();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        checks++;
        if (frame_dropped !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b want 1", frame_dropped); end
        step();
        checks++;
        if (frame_dropped !== 1'b0) begin errors++; $display("FAIL drop_width: got %b want 0", frame_dropped); end
        repeat (5) step();
        frame_end = 1'b1; step(); frame_end = 1'b0;
        wait_result(ok);
        checks++;
        if (!ok || peak_x !== 8'd50 || peak_x_count !== 8'd20 || peak_y !== 8'd60 || peak_y_count !== 8'd30) begin
            errors++; $display("FAIL drop_result: got %0d/%0d %0d/%0d want 50/20 60/30",
                               peak_x, peak_x_count, peak_y, peak_y_count);
        end
        accept();
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || n_start - s0 !== 1 || n_drop - d0 !== 1) begin
            errors++; $display("FAIL drop_no_rearm: busy=%b starts=%0d drops=%0d want 0 1 1",
                               busy, n_start - s0, n_drop - d0);
        end
    endtask

    task automatic test_backpressure();
        bit ok; int bad = 0;
        set_bins(); xq[239] = 8'd255; yq[100] = 8'd128; yq[101] = 8'd128;
        run_frame(1'b0, ok);
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (!ok || result_valid !== 1'b1 || peak_x !== 8'd239 || peak_x_count !== 8'd255 ||
                peak_y !== 8'd100 || peak_y_count !== 8'd128) begin
                errors++; bad++;
                if (bad < 4) $display("FAIL hold_stable cyc %0d: valid=%b x=%0d/%0d y=%0d/%0d want 1 239/255 100/128",
                                      i, result_valid, peak_x, peak_x_count, peak_y, peak_y_count);
            end
            step();
        end
        accept();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_accept: valid=%b busy=%b want 0 0", result_valid, busy);
        end
    endtask

    task automatic test_reset_in_read();
        bit ok; int k = 0, s0, c0, d0;
        set_bins(); xq[17] = 8'd5;
        frame_start = 1'b1; step(); frame_start = 1'b0;
        repeat (10) step();
        frame_end = 1'b1; step(); frame_end = 1'b0;
        while (x_valid !== 1'b1 && k < 200) begin step(); k++; end
        repeat (30) step();
        checks++;
        if (x_valid !== 1'b1) begin errors++; $display("FAIL rst_reach_read: x_valid=%b want 1", x_valid); end
        reset = 1'b1; step();
        checks++;
        if ({start_histogram, stop_histogram, read_histogram, clear_histogram, result_valid, busy,
             frame_dropped, peak_x, peak_x_count, peak_y, peak_y_count} !== '0) begin
            errors++; $display("FAIL rst_read_outputs: busy=%b peak_x=%0d want all 0", busy, peak_x);
        end
        s0 = n_start; c0 = n_clear; d0 = n_drop;
        step();
        reset = 1'b0; frame_start = 1'b1; step(); frame_start = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || n_start !== s0 || n_clear - c0 !== 1) begin
            errors++; $display("FAIL rst_reinit: idle=%b starts=%0d clears=%0d want 1 0 1", ok, n_start - s0, n_clear - c0);
        end
        checks++;
        if (n_drop - d0 !== 1) begin errors++; $display("FAIL rst_init_drop: got %0d want 1", n_drop - d0); end
    endtask

    initial begin
        set_bins();
        test_reset();
        test_peak_basic();
        test_tie();
        test_saturate_zero();
        test_drop();
        test_backpressure();
        test_reset_in_read();
        checks++;
        if (n_wide !== 0) begin errors++; $display("FAIL cmd_width: %0d multi-cycle commands want 0", n_wide); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
